softproc_pio_debounce: RTL

//  Input conditioner directly upstream of the single-bit softproc PIO input port.

---
 rtl/softproc_pio_pkg.sv | 14 +
 rtl/softproc_pio_debounce_if.sv | 41 ++++
 rtl/softproc_sync_chain.sv | 24 ++
 rtl/softproc_pio_debounce.sv | 121 ++++++++++++
 4 files changed

// File: rtl/softproc_pio_pkg.sv
// Shared types and default constants for the softproc PIO input conditioner.
// Optional glitch counter is controlled by the PSS_GLITCH_COUNT_EN macro (see top).
package softproc_pio_pkg;

    // Debounce FSM: STABLE waits for a level change, QUALIFY counts its persistence.
    typedef enum logic {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1000;

endpackage

// File: rtl/softproc_pio_debounce_if.sv
// Signal bundle between the external line / local logic and the debouncer.
// There is no valid/ready handshake here: raw_in, enable and glitch_clr are
// levels sampled every clock; clean_out is a level, rise/fall are one-cycle strobes.
// dbg_state/dbg_cnt expose the FSM for observation only.
// glitch_clr/glitch_cnt exist only when PSS_GLITCH_COUNT_EN is defined.
interface softproc_pio_debounce_if
    import softproc_pio_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int GLITCH_W = 8
);
    logic                raw_in;
    logic                enable;
    logic                clean_out;
    logic                rise_pulse;
    logic                fall_pulse;
    state_t              dbg_state;
    logic [CNT_W-1:0]    dbg_cnt;
`ifdef PSS_GLITCH_COUNT_EN
    logic                glitch_clr;
    logic [GLITCH_W-1:0] glitch_cnt;

    modport master (
        output raw_in, enable, glitch_clr,
        input  clean_out, rise_pulse, fall_pulse, dbg_state, dbg_cnt, glitch_cnt
    );
    modport slave (
        input  raw_in, enable, glitch_clr,
        output clean_out, rise_pulse, fall_pulse, dbg_state, dbg_cnt, glitch_cnt
    );
`else
    modport master (
        output raw_in, enable,
        input  clean_out, rise_pulse, fall_pulse, dbg_state, dbg_cnt
    );
    modport slave (
        input  raw_in, enable,
        output clean_out, rise_pulse, fall_pulse, dbg_state, dbg_cnt
    );
`endif
endinterface

// File: rtl/softproc_sync_chain.sv
// N-flop synchroniser for a single asynchronous bit; resets to IDLE_LEVEL so
// the debouncer sees the idle level until real samples arrive.
module softproc_sync_chain #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain_q;

    // Shift the raw sample through the chain; the top bit is the synchronised value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= {STAGES{IDLE_LEVEL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];
endmodule

// File: rtl/softproc_pio_debounce.sv
// Input conditioner feeding the single-bit softproc PIO in_port.
// Synchronises raw_in, then requires the new level to persist DEBOUNCE_CYCLES
// qualify cycles before clean_out follows. Rejected transitions are counted
// when the PSS_GLITCH_COUNT_EN macro is defined.
module softproc_pio_debounce
    import softproc_pio_pkg::*;
#(
    parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int   CNT_W           = 16,
    parameter logic IDLE_LEVEL      = 1'b1,
    parameter int   GLITCH_W        = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    softproc_pio_debounce_if.slave bus
);
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("softproc_pio_debounce: SYNC_STAGES must be 2..4");
    end
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2**CNT_W) - 1) begin : g_bad_deb
        $error("softproc_pio_debounce: DEBOUNCE_CYCLES out of range for CNT_W");
    end
    if (GLITCH_W < 1) begin : g_bad_glitch
        $error("softproc_pio_debounce: GLITCH_W must be at least 1");
    end

    localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             sync_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clean_q;
    logic             rise_q;
    logic             fall_q;

    softproc_sync_chain #(
        .STAGES     (SYNC_STAGES),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (bus.raw_in),
        .q       (sync_q)
    );

    // Qualify FSM: clean_out only moves after the new level survives the full count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            clean_q <= IDLE_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (!bus.enable) begin
                state_q <= STABLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    STABLE: begin
                        if (sync_q != clean_q) begin
                            state_q <= QUALIFY;
                            cnt_q   <= CNT_ONE;
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    QUALIFY: begin
                        if (sync_q == clean_q) begin
                            state_q <= STABLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == DEB_LIMIT) begin
                            clean_q <= ~clean_q;
                            rise_q  <= ~clean_q;
                            fall_q  <= clean_q;
                            state_q <= STABLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.clean_out  = clean_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_cnt    = cnt_q;

`ifdef PSS_GLITCH_COUNT_EN
    logic [GLITCH_W-1:0] glitch_q;
    logic                glitch_evt;

    // A qualification abandoned because the line fell back is a glitch.
    assign glitch_evt = bus.enable && (state_q == QUALIFY) && (sync_q == clean_q);

    // Saturating glitch counter; a clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_q <= '0;
        end else if (bus.glitch_clr) begin
            glitch_q <= '0;
        end else if (glitch_evt && (glitch_q != {GLITCH_W{1'b1}})) begin
            glitch_q <= glitch_q + GLITCH_W'(1);
        end
    end

    assign bus.glitch_cnt = glitch_q;
`endif
endmodule
